// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - runtime-programmable modulus up/down counter with terminal count
module modn_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int N_DEFAULT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH:0]   mod_q,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH:0]   MOD_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   MOD_TWO  = (WIDTH+1)'(2);
  localparam logic [WIDTH:0]   MOD_MAX  = (WIDTH+1)'(2**WIDTH);
  localparam logic [WIDTH:0]   MOD_RST  = (WIDTH+1)'(N_DEFAULT);
  localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] Q_ZERO   = '0;

  // A modulus outside 2..2^WIDTH would make the counter range meaningless.
  if (N_DEFAULT < 2 || N_DEFAULT > 2**WIDTH) begin : g_bad_n_default
    $fatal(1, "modn_updown_counter: N_DEFAULT out of range 2..2^WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   mod_q_q, mod_q_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             mod_legal;
  logic [WIDTH:0]   eff_mod;
  logic [WIDTH:0]   eff_max;
  logic [WIDTH-1:0] eff_max_q;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   load_ext;

  // Modulus write validation and the modulus that governs this cycle's q update.
  always_comb begin
    mod_legal = mod_wr && (mod_val >= MOD_TWO) && (mod_val <= MOD_MAX);
    eff_mod   = mod_legal ? mod_val : mod_q_q;
    eff_max   = eff_mod - MOD_ONE;
    // eff_mod never exceeds 2^WIDTH, so its top index always fits in WIDTH bits.
    eff_max_q = eff_max[WIDTH-1:0];
    q_ext     = {1'b0, q_q};
    load_ext  = {1'b0, load_val};
  end

  // Next-state: load beats modulus-shrink reset, which beats counting; wrap/err are one-cycle pulses.
  always_comb begin
    q_d     = q_q;
    mod_q_d = mod_legal ? mod_val : mod_q_q;
    wrap_d  = 1'b0;
    err_d   = mod_wr && !mod_legal;
    if (load) begin
      q_d = (load_ext <= eff_max) ? load_val : eff_max_q;
    end else if (mod_legal && (q_ext >= eff_mod)) begin
      q_d = Q_ZERO;
    end else if (en && up) begin
      if (q_q == eff_max_q) begin
        q_d    = Q_ZERO;
        wrap_d = 1'b1;
      end else begin
        q_d = q_q + Q_ONE;
      end
    end else if (en && !up) begin
      if (q_q == Q_ZERO) begin
        q_d    = eff_max_q;
        wrap_d = 1'b1;
      end else begin
        q_d = q_q - Q_ONE;
      end
    end
  end

  // State registers; asynchronous reset drops any pending wrap/err pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q     <= Q_ZERO;
      mod_q_q <= MOD_RST;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      mod_q_q <= mod_q_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Terminal count is combinational so a cascaded stage can use it as its enable in the same cycle.
  always_comb begin
    tc = en && (up ? (q_ext == (mod_q_q - MOD_ONE)) : (q_q == Q_ZERO));
  end

  assign q     = q_q;
  assign mod_q = mod_q_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule
